// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC/N/data/CHK frames, writes 32-bit words to
// program memory and holds the core in reset until a checksum-verified image is loaded.
module program_loader #(
    parameter int          MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_reset_o,
    output logic        done_o,
    output logic        error_o,
    output logic [7:0]  words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;
    logic        cpu_reset_q;
    logic        done_q;
    logic        error_q;
    logic [7:0]  words_q;
    logic [7:0]  n_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;
    logic [7:0]  chk_q;

    logic        xfer_s;
    logic        is_sync_s;
    logic        n_bad_s;

    function automatic logic ready_of(input state_t s);
        return !((s == S_WRITE) || (s == S_DONE));
    endfunction

    assign xfer_s    = byte_valid_i & ready_q;
    assign is_sync_s = (byte_data_i == SYNC_BYTE);
    assign n_bad_s   = (byte_data_i == 8'd0) || ({24'd0, byte_data_i} > 32'(MEMORY_DEPTH));

    // Next-state decode for the frame parser.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (xfer_s && is_sync_s) state_d = S_COUNT; else state_d = state_q;
            S_COUNT: if (xfer_s) state_d = n_bad_s ? S_ERROR : S_DATA; else state_d = state_q;
            S_DATA:  if (xfer_s && (byte_cnt_q == 2'd3)) state_d = S_WRITE; else state_d = state_q;
            S_WRITE: if ((words_q + 8'd1) == n_q) state_d = S_CHECK; else state_d = S_DATA;
            S_CHECK: if (xfer_s) state_d = (byte_data_i == chk_q) ? S_DONE : S_ERROR;
                     else state_d = state_q;
            S_DONE:  state_d = S_DONE;
            S_ERROR: if (xfer_s && is_sync_s) state_d = S_COUNT; else state_d = state_q;
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs; status flags follow the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_data_q  <= 32'd0;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= 8'd0;
            n_q         <= 8'd0;
            byte_cnt_q  <= 2'd0;
            word_q      <= 32'd0;
            chk_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_of(state_d);
            mem_write_q <= (state_d == S_WRITE);
            done_q      <= (state_d == S_DONE);
            cpu_reset_q <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERROR);
            case (state_q)
                S_COUNT: begin
                    if (xfer_s && !n_bad_s) begin
                        n_q        <= byte_data_i;
                        words_q    <= 8'd0;
                        byte_cnt_q <= 2'd0;
                        chk_q      <= byte_data_i;
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        word_q[8*byte_cnt_q +: 8] <= byte_data_i;
                        chk_q      <= chk_q ^ byte_data_i;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            mem_addr_q <= BASE_ADDR + {22'd0, words_q, 2'b00};
                            mem_data_q <= {byte_data_i, word_q[23:0]};
                        end
                    end
                end
                S_WRITE: words_q <= words_q + 8'd1;
                default: ;
            endcase
        end
    end

    assign byte_ready_o   = ready_q;
    assign mem_write_o    = mem_write_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;
    assign cpu_reset_o    = cpu_reset_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued by the stimulus
// and checked by an independent monitor; status flags are checked after each frame.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'd0;
    logic        byte_ready_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_reset_o;
    logic        done_o;
    logic        error_o;
    logic [7:0]  words_loaded_o;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    bit gaps = 1'b0;

    program_loader dut (
        .clk(clk), .reset(reset),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
        .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .cpu_reset_o(cpu_reset_o), .done_o(done_o), .error_o(error_o),
        .words_loaded_o(words_loaded_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && mem_write_o) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                         mem_addr_o, mem_data_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({mem_addr_o, mem_data_o} !== e) begin
                    fails++;
                    $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                             mem_addr_o, mem_data_o, e[63:32], e[31:0]);
                end
            end
            tests++;
            if (byte_ready_o !== 1'b0) begin
                fails++;
                $display("FAIL ready_in_write: got %0b expected 0", byte_ready_o);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        n = 0;
        while (byte_ready_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: byte 0x%02h never accepted", b);
        end else begin
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Sends SYNC, N, N words and checksum; queues the expected writes.
    task automatic send_frame(input logic [7:0] n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input bit flip);
        logic [31:0] w[3];
        logic [7:0]  chk;
        w[0] = w0; w[1] = w1; w[2] = w2;
        chk = n;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({32'(4 * i), w[i]});
            chk = chk ^ w[i][7:0] ^ w[i][15:8] ^ w[i][23:16] ^ w[i][31:24];
        end
        send_byte(8'hA5);
        send_byte(n);
        for (int i = 0; i < int'(n); i++) send_word(w[i]);
        send_byte(flip ? ~chk : chk);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c,
                                input logic [7:0] wl);
        check({tag, "_done"}, 32'(done_o), 32'(d));
        check({tag, "_error"}, 32'(error_o), 32'(e));
        check({tag, "_cpu_reset"}, 32'(cpu_reset_o), 32'(c));
        check({tag, "_words"}, 32'(words_loaded_o), 32'(wl));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        check({tag, "_write"}, 32'(mem_write_o), 32'd0);
        check({tag, "_addr"}, mem_addr_o, 32'd0);
        check({tag, "_data"}, mem_data_o, 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // 1: minimal frame, hand-written checksum 0x12
        exp_q.push_back({32'h0, 32'h0000_0013});
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h12);
        repeat (2) @(negedge clk);
        check_status("t1", 1'b1, 1'b0, 1'b1, 8'd1);
        check("t1_ready_done", 32'(byte_ready_o), 32'd0);

        // 2: three words, checksum 0x60
        do_reset();
        send_frame(8'd3, 32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 1'b0);
        check_status("t2", 1'b1, 1'b0, 1'b1, 8'd3);

        // 3: N beyond depth
        do_reset();
        send_byte(8'hA5); send_byte(8'h41);
        repeat (3) @(negedge clk);
        check("t3_error", 32'(error_o), 32'd1);
        check("t3_cpu_reset", 32'(cpu_reset_o), 32'd0);
        check("t3_done", 32'(done_o), 32'd0);

        // 4: bad checksum then retry from ERROR
        send_byte(8'hA5);
        @(negedge clk);
        check("t4_error_cleared", 32'(error_o), 32'd0);
        send_byte(8'd2);
        exp_q.push_back({32'h0, 32'h1111_2222});
        exp_q.push_back({32'h4, 32'h3333_4444});
        send_word(32'h1111_2222); send_word(32'h3333_4444);
        send_byte(8'h02 ^ 8'h00 ^ 8'hFF);
        repeat (2) @(negedge clk);
        check_status("t4_bad", 1'b0, 1'b1, 1'b0, 8'd2);
        send_frame(8'd2, 32'h1111_2222, 32'h3333_4444, 32'h0, 1'b0);
        check_status("t4_good", 1'b1, 1'b0, 1'b1, 8'd2);

        // 5: junk before sync and random stalls
        do_reset();
        gaps = 1'b1;
        send_byte(8'h00); send_byte(8'hFF);
        send_frame(8'd3, 32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 1'b0);
        gaps = 1'b0;
        check_status("t5", 1'b1, 1'b0, 1'b1, 8'd3);

        // 6: reset in the middle of word 2
        do_reset();
        exp_q.push_back({32'h0, 32'hDEAD_BEEF});
        send_byte(8'hA5); send_byte(8'h03);
        send_word(32'hDEAD_BEEF);
        send_byte(8'h01); send_byte(8'h02);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("t6_abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_frame(8'd1, 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        check_status("t6_reload", 1'b1, 1'b0, 1'b1, 8'd1);

        repeat (3) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
